spi: RTL and testbench

SPI -- requirements
Module: spi

---
 rtl/spi.sv | 98 +++++++++
 tb/tb_spi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi.sv
// SPI mode-0 slave: all SPI inputs are resampled in sys_clk; sends a 16-bit word on miso and
// receives bytes on mosi, reporting the last full byte when the frame ends.
module spi (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [15:0] tx_data,
  input  logic        load,
  output logic        tx_ready,
  output logic        status,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        spi_clk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e      state_q, state_d;
  logic        sclk_q, sclk_dq, cs_q, cs_dq, mosi_q;
  logic [15:0] tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        sclk_rise, cs_fall, cs_rise;

  assign sclk_rise = sclk_q & ~sclk_dq;
  assign cs_fall   = ~cs_q & cs_dq;
  assign cs_rise   = cs_q & ~cs_dq;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sclk_q     <= 1'b0;
      sclk_dq    <= 1'b0;
      cs_q       <= 1'b1;
      cs_dq      <= 1'b1;
      mosi_q     <= 1'b0;
      state_q    <= StIdle;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sclk_q     <= spi_clk;
      sclk_dq    <= sclk_q;
      cs_q       <= cs;
      cs_dq      <= cs_q;
      mosi_q     <= mosi;
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StActive;
      StActive: if (cs_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // End of frame wins over everything; a short frame leaves rx_data untouched.
    if (cs_rise) begin
      if (cnt_q >= 5'd8) begin
        rx_data_d  = rx_sr_q;
        rx_valid_d = 1'b1;
      end
      cnt_d   = '0;
      tx_sr_d = '0;
    end else if (state_q == StIdle) begin
      if (load) tx_sr_d = tx_data;
    end else if (sclk_rise) begin
      tx_sr_d = {tx_sr_q[14:0], 1'b0};
      rx_sr_d = {rx_sr_q[6:0], mosi_q};
      if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
    end
  end

  assign miso     = ~cs & tx_sr_q[15];
  assign status   = (state_q == StActive);
  assign tx_ready = ~status;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi.sv
// Directed bench for the spi slave: an SPI master model drives mode-0 frames and every
// expected value is a hand-computed constant.
module tb_spi;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [15:0] tx_data;
  logic        load;
  logic        tx_ready, status, rx_valid, miso;
  logic [7:0]  rx_data;
  logic        spi_clk, cs, mosi;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;

  spi dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .load     (load),
    .tx_ready (tx_ready),
    .status   (status),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .spi_clk  (spi_clk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #10 sys_clk = ~sys_clk;

  // Counts every sys_clk cycle with rx_valid high; frames compare before/after snapshots.
  always @(negedge sys_clk) if (rx_valid) vcnt <= vcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d);
    @(negedge sys_clk);
    tx_data = d;
    load    = 1'b1;
    @(negedge sys_clk);
    load    = 1'b0;
  endtask

  task automatic cs_low();
    @(posedge sys_clk);
    #5 cs = 1'b0;
    #40;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #20 spi_clk = 1'b1;
    m = miso;
    #20 spi_clk = 1'b0;
  endtask

  task automatic cs_high();
    #20 cs = 1'b1;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic run_frame(input logic [15:0] mo, input int n,
                           output logic [15:0] mi, output logic mid_status);
    logic m;
    mi = '0;
    mid_status = 1'b0;
    cs_low();
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(mo[i], m);
      mi = {mi[14:0], m};
      if (i == n / 2) begin
        #3 mid_status = status;
      end
    end
    cs_high();
  endtask

  logic [15:0] word;
  logic        st, m;
  int          v0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0; load = 1'b0; tx_data = '0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_status",   32'(status),   32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  32'(rx_data),  32'h00);
    chk("rst_miso",     32'(miso),     32'd0);

    // Transmit A5C3 over a full 16-bit frame.
    do_load(16'hA5C3);
    v0 = vcnt;
    run_frame(16'h0000, 16, word, st);
    chk("tx_a5c3",      32'(word),      32'hA5C3);
    chk("status_frame", 32'(st),        32'd1);
    chk("rx_after_16",  32'(rx_data),   32'h00);
    chk("pulse_16",     32'(vcnt - v0), 32'd1);
    chk("status_idle",  32'(status),    32'd0);
    chk("ready_idle",   32'(tx_ready),  32'd1);

    // Receive 5A; tx register was cleared, so miso stays low.
    v0 = vcnt;
    run_frame(16'h005A, 8, word, st);
    chk("rx_5a",        32'(rx_data),   32'h5A);
    chk("pulse_5a",     32'(vcnt - v0), 32'd1);
    chk("miso_no_load", 32'(word),      32'h0000);

    // Aborted 4-bit frame.
    v0 = vcnt;
    run_frame(16'h000F, 4, word, st);
    chk("abort_rx",    32'(rx_data),   32'h5A);
    chk("abort_pulse", 32'(vcnt - v0), 32'd0);
    run_frame(16'h0000, 16, word, st);
    chk("tx_cleared",  32'(word),      32'h0000);
    chk("rx_zero",     32'(rx_data),   32'h00);

    // Load during ACTIVE must be ignored.
    do_load(16'h1234);
    v0 = vcnt;
    word = '0;
    cs_low();
    for (int i = 15; i >= 0; i--) begin
      logic [15:0] mo;
      mo = 16'h00C3;
      spi_bit(mo[i], m);
      word = {word[14:0], m};
      if (i == 12) begin
        @(negedge sys_clk);
        tx_data = 16'hFFFF;
        load    = 1'b1;
        @(negedge sys_clk);
        load    = 1'b0;
      end
    end
    cs_high();
    chk("tx_1234",    32'(word),      32'h1234);
    chk("rx_c3",      32'(rx_data),   32'hC3);
    chk("pulse_c3",   32'(vcnt - v0), 32'd1);

    // Reset in the middle of a frame.
    do_load(16'hBEEF);
    v0 = vcnt;
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    #5 rst = 1'b1;
    #1;
    chk("mid_rst_status",   32'(status),   32'd0);
    chk("mid_rst_ready",    32'(tx_ready), 32'd1);
    chk("mid_rst_miso",     32'(miso),     32'd0);
    chk("mid_rst_rx_data",  32'(rx_data),  32'h00);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    cs = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    repeat (6) @(negedge sys_clk);
    chk("mid_rst_pulse",  32'(vcnt - v0), 32'd0);
    chk("post_rst_state", 32'(status),    32'd0);

    // Fresh frame after reset.
    do_load(16'h8001);
    run_frame(16'h0000, 16, word, st);
    chk("tx_8001", 32'(word), 32'h8001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
